pipe_hazard_ctrl: RTL and testbench

- Central sequencer for the four pipeline buffers (IF_ID, ID_EXE, EXE_MEM, MEM_WB) and the PC register.
- Generates every per-stage go (hold) and clear (bubble) strobe from load-use hazards, taken branches, multi-cycle mult/div occupancy and syscall halt/resume.
- Sits beside the datapath: decode fields come from ID, hazard sources from EXE, and the strobes drive the buffers' go/clear pins directly.

---
 rtl/pipe_pkg.sv | 33 +++
 rtl/load_use_detect.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM state encoding, register-index width and control-bundle bit positions.
package pipe_pkg;

  localparam int unsigned PIPE_REG_W = 5;

  typedef enum logic [1:0] {
    PIPE_ST_RUN     = 2'd0,
    PIPE_ST_MD_BUSY = 2'd1,
    PIPE_ST_HALT    = 2'd2
  } pipe_st_e;

  // Control bundle: go strobes in the low bits, clear strobes above them.
  localparam int unsigned CTRL_W            = 8;
  localparam int unsigned CTRL_PC_GO        = 0;
  localparam int unsigned CTRL_IF_ID_GO     = 1;
  localparam int unsigned CTRL_ID_EXE_GO    = 2;
  localparam int unsigned CTRL_EXE_MEM_GO   = 3;
  localparam int unsigned CTRL_MEM_WB_GO    = 4;
  localparam int unsigned CTRL_IF_ID_CLEAR  = 5;
  localparam int unsigned CTRL_ID_EXE_CLEAR = 6;
  localparam int unsigned CTRL_EXE_MEM_CLR  = 7;

  localparam logic [CTRL_W-1:0] CTRL_ALL_GO  = 8'b0001_1111;
  localparam logic [CTRL_W-1:0] CTRL_ALL_CLR = 8'b1110_0000;

  // Hold PC/IF_ID/ID_EXE while mult/div occupies EXE; bubble into EXE_MEM.
  localparam logic [CTRL_W-1:0] CTRL_MD_STALL = 8'b1001_1000;
  // Hold PC/IF_ID for one cycle and bubble into ID_EXE.
  localparam logic [CTRL_W-1:0] CTRL_LOAD_USE = 8'b0101_1100;
  localparam logic [CTRL_W-1:0] CTRL_BRANCH   = 8'b0111_1111;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection between the EXE load and the ID reader.
module load_use_detect
  import pipe_pkg::*;
#(
  parameter int unsigned REG_W = PIPE_REG_W
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             exe_mem_read,
  input  logic [REG_W-1:0] exe_rd,
  output logic             load_use
);

  always_comb begin
    load_use = exe_mem_read && (exe_rd != '0) &&
               ((id_use_rs && (id_rs == exe_rd)) ||
                (id_use_rt && (id_rt == exe_rd)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: per-stage go/clear strobes from hazards, branches, mult/div and halt.
// Optional statistics counters are enabled with `define PIPE_HAZARD_CTRL_STATS_EN.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned REG_W  = PIPE_REG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             exe_mem_read,
  input  logic [REG_W-1:0] exe_rd,
  input  logic             exe_branch_taken,
  input  logic             exe_md_start,
  input  logic             exe_halt,
  input  logic             resume,
  output logic             pc_go,
  output logic             if_id_go,
  output logic             id_exe_go,
  output logic             exe_mem_go,
  output logic             mem_wb_go,
  output logic             if_id_clear,
  output logic             id_exe_clear,
  output logic             exe_mem_clear,
  output logic             halted,
  output logic             md_busy
`ifdef PIPE_HAZARD_CTRL_STATS_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_count
`endif
);

  pipe_st_e          st, st_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [CTRL_W-1:0] ctrl;
  logic              load_use;

  load_use_detect #(.REG_W(REG_W)) u_lud (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .exe_mem_read (exe_mem_read),
    .exe_rd       (exe_rd),
    .load_use     (load_use)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= PIPE_ST_RUN;
      cnt <= '0;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
    end
  end

  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    ctrl  = CTRL_ALL_GO;
    unique case (st)
      PIPE_ST_RUN: begin
        if (exe_halt) begin
          ctrl = '0;
          st_n = PIPE_ST_HALT;
        end else if (exe_md_start) begin
          ctrl  = CTRL_MD_STALL;
          cnt_n = CNT_W'(MD_LAT - 1);
          st_n  = PIPE_ST_MD_BUSY;
        end else if (exe_branch_taken) begin
          ctrl = CTRL_BRANCH;
        end else if (load_use) begin
          ctrl = CTRL_LOAD_USE;
        end
      end
      PIPE_ST_MD_BUSY: begin
        if (cnt != '0) begin
          ctrl  = CTRL_MD_STALL;
          cnt_n = cnt - 1'b1;
        end else begin
          st_n = PIPE_ST_RUN;
        end
      end
      PIPE_ST_HALT: begin
        if (resume) begin
          st_n = PIPE_ST_RUN;
        end else begin
          ctrl = '0;
        end
      end
      default: st_n = PIPE_ST_RUN;
    endcase
    // Reset overrides the decode so held buffers flush while rst_n is low.
    if (!rst_n) ctrl = CTRL_ALL_CLR;
  end

  assign pc_go         = ctrl[CTRL_PC_GO];
  assign if_id_go      = ctrl[CTRL_IF_ID_GO];
  assign id_exe_go     = ctrl[CTRL_ID_EXE_GO];
  assign exe_mem_go    = ctrl[CTRL_EXE_MEM_GO];
  assign mem_wb_go     = ctrl[CTRL_MEM_WB_GO];
  assign if_id_clear   = ctrl[CTRL_IF_ID_CLEAR];
  assign id_exe_clear  = ctrl[CTRL_ID_EXE_CLEAR];
  assign exe_mem_clear = ctrl[CTRL_EXE_MEM_CLR];
  assign halted        = (st == PIPE_ST_HALT);
  assign md_busy       = (st == PIPE_ST_MD_BUSY);

`ifdef PIPE_HAZARD_CTRL_STATS_EN
  logic flush_hit;
  assign flush_hit = (st == PIPE_ST_RUN) && !exe_halt && !exe_md_start && exe_branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!ctrl[CTRL_PC_GO]) stall_cycles <= stall_cycles + 32'd1;
      if (flush_hit)         flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// against a cycle-level behavioural model (stats checked when PIPE_HAZARD_CTRL_STATS_EN).
module tb_pipe_hazard_ctrl;

  localparam int unsigned MD_LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, exe_rd;
  logic       id_use_rs, id_use_rt, exe_mem_read;
  logic       exe_branch_taken, exe_md_start, exe_halt, resume;
  logic       pc_go, if_id_go, id_exe_go, exe_mem_go, mem_wb_go;
  logic       if_id_clear, id_exe_clear, exe_mem_clear, halted, md_busy;
`ifdef PIPE_HAZARD_CTRL_STATS_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Model state: halt flag and number of remaining post-trigger mult/div cycles.
  bit          m_halt;
  int unsigned m_md;
  logic [31:0] m_stall, m_flush;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(4), .REG_W(5)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_use_rs        (id_use_rs),
    .id_use_rt        (id_use_rt),
    .exe_mem_read     (exe_mem_read),
    .exe_rd           (exe_rd),
    .exe_branch_taken (exe_branch_taken),
    .exe_md_start     (exe_md_start),
    .exe_halt         (exe_halt),
    .resume           (resume),
    .pc_go            (pc_go),
    .if_id_go         (if_id_go),
    .id_exe_go        (id_exe_go),
    .exe_mem_go       (exe_mem_go),
    .mem_wb_go        (mem_wb_go),
    .if_id_clear      (if_id_clear),
    .id_exe_clear     (id_exe_clear),
    .exe_mem_clear    (exe_mem_clear),
    .halted           (halted),
    .md_busy          (md_busy)
`ifdef PIPE_HAZARD_CTRL_STATS_EN
    ,
    .stall_cycles     (stall_cycles),
    .flush_count      (flush_count)
`endif
  );

  // {pc, if_id, id_exe, exe_mem, mem_wb} go then {if_id, id_exe, exe_mem} clear
  function automatic logic [7:0] dut_vec();
    return {pc_go, if_id_go, id_exe_go, exe_mem_go, mem_wb_go,
            if_id_clear, id_exe_clear, exe_mem_clear};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; exe_rd = '0;
    id_use_rs = 0; id_use_rt = 0; exe_mem_read = 0;
    exe_branch_taken = 0; exe_md_start = 0; exe_halt = 0; resume = 0;
  endtask

  task automatic model_reset();
    m_halt = 0; m_md = 0; m_stall = '0; m_flush = '0;
  endtask

  function automatic logic [7:0] model_vec();
    logic [4:0] go;
    logic [2:0] clr;
    bit lu;
    lu = exe_mem_read && exe_rd != 0 &&
         ((id_use_rs && id_rs == exe_rd) || (id_use_rt && id_rt == exe_rd));
    go = 5'b11111; clr = 3'b000;
    if (m_halt) begin
      if (!resume) go = 5'b00000;
    end else if (m_md > 0) begin
      if (m_md > 1) begin go = 5'b00011; clr = 3'b001; end
    end else if (exe_halt) go = 5'b00000;
    else if (exe_md_start) begin go = 5'b00011; clr = 3'b001; end
    else if (exe_branch_taken) clr = 3'b110;
    else if (lu) begin go = 5'b00111; clr = 3'b010; end
    return {go, clr};
  endfunction

  // Compare against the model now, then advance one clock and update the model.
  task automatic step();
    logic [7:0] ev;
    bit flush;
    ev = model_vec();
    chk("ctrl", 32'(dut_vec()), 32'(ev));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("md_busy", 32'(md_busy), 32'(m_md > 0));
`ifdef PIPE_HAZARD_CTRL_STATS_EN
    chk("stall_cycles", stall_cycles, m_stall);
    chk("flush_count", flush_count, m_flush);
`endif
    flush = !m_halt && m_md == 0 && !exe_halt && !exe_md_start && exe_branch_taken;
    @(posedge clk);
    if (!ev[7]) m_stall++;
    if (flush) m_flush++;
    if (m_halt) begin
      if (resume) m_halt = 0;
    end else if (m_md > 0) m_md--;
    else if (exe_halt) m_halt = 1;
    else if (exe_md_start) m_md = MD_LAT;
    #1;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst_n = 0;
    #2;
    chk("reset_ctrl", 32'(dut_vec()), 32'h07);
    chk("reset_halted", 32'(halted), 32'h0);
    chk("reset_md_busy", 32'(md_busy), 32'h0);
    @(posedge clk); #1;
    rst_n = 1;

    // Idle
    #4; chk("idle_ctrl", 32'(dut_vec()), 32'hF8); step();

    // Load-use on rs: one bubble cycle
    exe_mem_read = 1; exe_rd = 5; id_rs = 5; id_use_rs = 1;
    #4; chk("lu_stall", 32'({pc_go, if_id_go, id_exe_clear}), 32'b001); step();
    clear_inputs();
    #4; chk("lu_after", 32'(dut_vec()), 32'hF8); step();

    // Load to r0 never stalls
    exe_mem_read = 1; exe_rd = 0; id_rs = 0; id_use_rs = 1;
    #4; chk("lu_r0", 32'(pc_go), 32'h1); step();

    // Branch beats load-use
    exe_mem_read = 1; exe_rd = 7; id_rt = 7; id_use_rt = 1; exe_branch_taken = 1;
    #4; chk("br_over_lu", 32'({pc_go, if_id_clear, id_exe_clear}), 32'b111); step();
    clear_inputs();

    // Mult/div held high through release: 4 stall cycles, release on the 5th
    exe_md_start = 1;
    for (int i = 0; i < 4; i++) begin
      #4; chk("md_stall", 32'({pc_go, exe_mem_clear}), 32'b01); step();
    end
    #4; chk("md_release", 32'(dut_vec()), 32'hF8); step();
    clear_inputs();
    #4; chk("md_done", 32'(md_busy), 32'h0); step();

    // Halt for 10 cycles, then resume
    exe_halt = 1;
    #4; chk("halt_trig", 32'(dut_vec()), 32'h00); step();
    clear_inputs();
    for (int i = 0; i < 10; i++) begin
      #4; chk("halt_hold", 32'({halted, pc_go, mem_wb_go}), 32'b100); step();
    end
    resume = 1;
    #4; chk("resume_go", 32'(dut_vec()), 32'hF8); step();
    resume = 0;
    #4; chk("resume_done", 32'(halted), 32'h0); step();

    // Reset in the middle of a mult/div sequence (cnt=2)
    exe_md_start = 1;
    #4; step();
    clear_inputs();
    #4; step();
    chk("md_pre_reset", 32'(md_busy), 32'h1);
    rst_n = 0; model_reset();
    #1;
    chk("md_reset_busy", 32'(md_busy), 32'h0);
    chk("md_reset_ctrl", 32'(dut_vec()), 32'h07);
    @(posedge clk); #1;
    rst_n = 1;
    #4; chk("post_reset", 32'(dut_vec()), 32'hF8); step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      exe_rd = 5'($urandom_range(0, 3));
      id_use_rs = 1'($urandom_range(0, 1));
      id_use_rt = 1'($urandom_range(0, 1));
      exe_mem_read = 1'($urandom_range(0, 1));
      exe_branch_taken = ($urandom_range(0, 5) == 0);
      exe_md_start = ($urandom_range(0, 11) == 0);
      exe_halt = ($urandom_range(0, 19) == 0);
      resume = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 0; model_reset();
        #1; chk("rand_reset_ctrl", 32'(dut_vec()), 32'h07);
        @(posedge clk); #1;
        rst_n = 1;
      end
      #4; step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
